// File: rtl/linear_result_streamer.sv
// Purpose : snapshot the linear layer's MATRIX_SIZE x MATRIX_SIZE result on done_in
//           and drain it row-major over a valid/ready stream.
// Latency : first element valid 1 cycle after done_in; back-to-back frames with no bubble.
// Backpr. : out_ready low holds out_data/out_row/out_col/out_last stable; done_in while busy
//           (other than on the final transfer) is dropped and sets sticky overrun.
// Ports   : clk/reset (sync, active-high); done_in + in_matrix[row][col] capture side;
//           out_valid/out_ready/out_data/out_row/out_col/out_last stream side;
//           busy, frame_done (pulse after final transfer), overrun (sticky) status.
module linear_result_streamer #(
   parameter int MATRIX_SIZE = 16,
   parameter int DATA_SIZE   = 8
) (
   input  logic                                                     clk,
   input  logic                                                     reset,
   input  logic                                                     done_in,
   input  logic [MATRIX_SIZE-1:0][MATRIX_SIZE-1:0][DATA_SIZE-1:0]   in_matrix,
   output logic                                                     busy,
   output logic                                                     out_valid,
   input  logic                                                     out_ready,
   output logic [DATA_SIZE-1:0]                                     out_data,
   output logic [$clog2(MATRIX_SIZE)-1:0]                           out_row,
   output logic [$clog2(MATRIX_SIZE)-1:0]                           out_col,
   output logic                                                     out_last,
   output logic                                                     frame_done,
   output logic                                                     overrun
);

   localparam int CW = $clog2(MATRIX_SIZE);
   localparam logic [CW-1:0] IDX_MAX = CW'(MATRIX_SIZE - 1);

   typedef enum logic {
      S_IDLE,
      S_STREAM
   } state_t;

   state_t                                                   state_q, state_d;
   logic [CW-1:0]                                            row_q, row_d;
   logic [CW-1:0]                                            col_q, col_d;
   logic                                                     fdone_q, fdone_d;
   logic                                                     ovr_q, ovr_d;
   logic [MATRIX_SIZE-1:0][MATRIX_SIZE-1:0][DATA_SIZE-1:0]   buf_q;
   logic                                                     buf_cap;
   logic                                                     xfer;
   logic                                                     at_last;

   assign at_last = (row_q == IDX_MAX) && (col_q == IDX_MAX);
   assign xfer    = out_valid && out_ready;

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      fdone_d = 1'b0;
      ovr_d   = ovr_q;
      buf_cap = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (done_in) begin
               buf_cap = 1'b1;
               row_d   = '0;
               col_d   = '0;
               state_d = S_STREAM;
            end
         end
         S_STREAM: begin
            if (xfer && at_last) begin
               // Frame complete; a coincident done_in starts the next frame
               // immediately so the stream never bubbles between frames.
               fdone_d = 1'b1;
               row_d   = '0;
               col_d   = '0;
               if (done_in) begin
                  buf_cap = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               if (xfer) begin
                  if (col_q == IDX_MAX) begin
                     col_d = '0;
                     row_d = row_q + CW'(1);
                  end else begin
                     col_d = col_q + CW'(1);
                  end
               end
               // Snapshot is still draining: the new result is lost.
               if (done_in) begin
                  ovr_d = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         row_q   <= '0;
         col_q   <= '0;
         fdone_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         fdone_q <= fdone_d;
         ovr_q   <= ovr_d;
      end
   end

   // Snapshot storage is intentionally not reset; contents are only read while streaming.
   always_ff @(posedge clk) begin
      if (buf_cap) begin
         buf_q <= in_matrix;
      end
   end

   assign out_valid  = (state_q == S_STREAM);
   assign busy       = (state_q == S_STREAM);
   assign out_last   = out_valid && at_last;
   assign out_data   = out_valid ? buf_q[row_q][col_q] : '0;
   assign out_row    = row_q;
   assign out_col    = col_q;
   assign frame_done = fdone_q;
   assign overrun    = ovr_q;

endmodule
